vc_fifo: RTL and testbench

- Per-virtual-channel buffer directly downstream of the VC0/VC1 demux; one instance per VC output (valid_0/dataout0, valid_1/dataout1).
- Stores 6-bit words pushed by the demux and releases them on a pop request from the next stage (arbiter/mux).
- Exposes full/empty, almost-full/almost-empty flags for flow control and a sticky overflow/underflow error.

---
 rtl/vc_fifo_if.sv | 31 +++
 rtl/vc_fifo.sv | 95 +++++++++
 tb/tb_vc_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vc_fifo_if.sv
// Handshake/data bundle between the VC demux, one per-VC FIFO and the downstream arbiter.
// Purely structural: carries no state and adds no latency.
// The FIFO side (slave) flags full/almost_full upstream so the demux can throttle pushes.
interface vc_fifo_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  fifo_error;

  // Producer/consumer side: drives requests, observes data and status.
  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
  );

  // FIFO side.
  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/vc_fifo.sv
// Per-virtual-channel word buffer sitting behind the VC0/VC1 demux.
// Latency: a popped word appears on data_out one cycle after the pop edge.
// Backpressure: push while full (no concurrent pop) is dropped and sets the sticky fifo_error.
module vc_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input logic     clk,
  input logic     reset,
  vc_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  fifo_error_q, fifo_error_d;

  logic pop_acc, push_acc, overflow, underflow;

  // Accept decisions and next-state; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    pop_acc      = bus.pop && (count_q != '0);
    push_acc     = bus.push && ((count_q != DEPTH_C) || pop_acc);
    overflow     = bus.push && !push_acc;
    underflow    = bus.pop && !pop_acc;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    valid_out_d  = pop_acc;
    fifo_error_d = fifo_error_q | overflow | underflow;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all stored words immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      fifo_error_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      fifo_error_q <= fifo_error_d;
    end
  end

  // Storage array, not reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.count        = count_q;
  assign bus.fifo_error   = fifo_error_q;
  assign bus.full         = (count_q == DEPTH_C);
  assign bus.empty        = (count_q == '0);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_vc_fifo.sv
// Self-checking bench for vc_fifo: directed scenarios plus random traffic against a queue model.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the edge.
// Pushes/pops are requested freely; the model decides acceptance exactly as a FIFO should.
module tb_vc_fifo;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  vc_fifo_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

  vc_fifo #(.DATA_WIDTH(6), .DEPTH(8), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of words plus the output registers it implies.
  logic [5:0] mq[$];
  logic [5:0] m_dout;
  bit         m_vld;
  bit         m_err;

  logic [5:0] fill_v [8] = '{6'h32, 6'h37, 6'h12, 6'h13, 6'h23, 6'h04, 6'h25, 6'h2D};

  task automatic model_clear();
    mq.delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
  endtask

  // One clock with the given requests; the model advances from its pre-edge occupancy.
  task automatic cyc(input bit p, input logic [5:0] d, input bit r);
    int  sz;
    bit  pop_ok, push_ok;
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = r;
    sz      = mq.size();
    pop_ok  = r && (sz > 0);
    push_ok = p && ((sz < 8) || pop_ok);
    if (pop_ok) m_dout = mq.pop_front();
    m_vld = pop_ok;
    if (push_ok) mq.push_back(d);
    if ((p && !push_ok) || (r && sz == 0)) m_err = 1'b1;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic apply_reset();
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.data_in = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp += 7;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", bus.empty); end
    if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %0b want 1", bus.almost_empty); end
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", bus.full); end
    if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.valid_out); end
    if (bus.data_out !== 6'h00) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", bus.data_out); end
    if (bus.fifo_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", bus.fifo_error); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, fill_v[k], 1'b0);
      n_cmp += 3;
      if (bus.count !== 4'(k + 1)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", bus.count, k + 1); end
      if (bus.almost_empty !== ((k + 1) <= 2)) begin n_fail++; $display("FAIL fill_ae at %0d: got %0b", k + 1, bus.almost_empty); end
      if (bus.almost_full !== ((k + 1) >= 6)) begin n_fail++; $display("FAIL fill_af at %0d: got %0b", k + 1, bus.almost_full); end
    end
    n_cmp += 2;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b want 1", bus.full); end
    if (bus.fifo_error !== 1'b0) begin n_fail++; $display("FAIL fill_err: got %0b want 0", bus.fifo_error); end
  endtask

  task automatic test_overflow_drain();
    cyc(1'b1, 6'h3F, 1'b0);
    n_cmp += 2;
    if (bus.fifo_error !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %0b want 1", bus.fifo_error); end
    if (bus.count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", bus.count); end
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 6'h00, 1'b1);
      n_cmp += 2;
      if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL drain_valid %0d: got %0b want 1", k, bus.valid_out); end
      if (bus.data_out !== fill_v[k]) begin n_fail++; $display("FAIL drain_data %0d: got %0h want %0h", k, bus.data_out, fill_v[k]); end
    end
    cyc(1'b0, 6'h00, 1'b0);
    n_cmp += 3;
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %0b want 1", bus.empty); end
    if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0b want 0", bus.valid_out); end
    if (bus.data_out !== 6'h2D) begin n_fail++; $display("FAIL idle_hold: got %0h want 2d", bus.data_out); end
  endtask

  task automatic test_wrap();
    logic [5:0] d;
    apply_reset();
    d = 6'h01;
    for (int k = 0; k < 5; k++) begin cyc(1'b1, d, 1'b0); d++; end
    for (int k = 0; k < 3; k++) cyc(1'b0, 6'h00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, d, 1'b1);
      d++;
      n_cmp += 3;
      if (bus.count !== 4'd2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", bus.count); end
      if (bus.valid_out !== 1'b1 || bus.data_out !== m_dout) begin
        n_fail++; $display("FAIL wrap_data: got %0b/%0h want 1/%0h", bus.valid_out, bus.data_out, m_dout);
      end
      if (bus.fifo_error !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %0b want 0", bus.fifo_error); end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 6'h00, 1'b1);
      n_cmp++;
      if (bus.data_out !== m_dout) begin n_fail++; $display("FAIL wrap_tail: got %0h want %0h", bus.data_out, m_dout); end
    end
  endtask

  task automatic test_boundary();
    apply_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 6'(k + 8), 1'b0);
    cyc(1'b1, 6'h30, 1'b1);
    n_cmp += 3;
    if (bus.count !== 4'd8) begin n_fail++; $display("FAIL full_pp_count: got %0d want 8", bus.count); end
    if (bus.fifo_error !== 1'b0) begin n_fail++; $display("FAIL full_pp_err: got %0b want 0", bus.fifo_error); end
    if (bus.data_out !== 6'h08) begin n_fail++; $display("FAIL full_pp_data: got %0h want 8", bus.data_out); end
    for (int k = 0; k < 8; k++) cyc(1'b0, 6'h00, 1'b1);
    n_cmp++;
    if (bus.data_out !== 6'h30) begin n_fail++; $display("FAIL full_pp_last: got %0h want 30", bus.data_out); end
    cyc(1'b1, 6'h11, 1'b1);
    n_cmp += 3;
    if (bus.count !== 4'd1) begin n_fail++; $display("FAIL empty_pp_count: got %0d want 1", bus.count); end
    if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL empty_pp_valid: got %0b want 0", bus.valid_out); end
    if (bus.fifo_error !== 1'b1) begin n_fail++; $display("FAIL empty_pp_err: got %0b want 1", bus.fifo_error); end
    cyc(1'b0, 6'h00, 1'b1);
    n_cmp++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 6'h11) begin
      n_fail++; $display("FAIL empty_pp_next: got %0b/%0h want 1/11", bus.valid_out, bus.data_out);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) cyc(1'b1, 6'(k + 6'h20), 1'b0);
    cyc(1'b1, 6'h24, 1'b1);
    n_cmp += 3;
    if (bus.count !== 4'd4 || bus.valid_out !== 1'b1 || bus.fifo_error !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got %0d/%0b/%0b want 4/1/1", bus.count, bus.valid_out, bus.fifo_error);
    end
    #2;
    reset = 1'b1;
    bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 6'h15;
    #1;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", bus.count); end
    if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", bus.valid_out); end
    if (bus.fifo_error !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %0b want 0", bus.fifo_error); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0;
    model_clear();
    n_cmp++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL mid_ignored: got %0d want 0", bus.count); end
    cyc(1'b1, 6'h2A, 1'b0);
    cyc(1'b0, 6'h00, 1'b1);
    n_cmp++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 6'h2A) begin
      n_fail++; $display("FAIL mid_after: got %0b/%0h want 1/2a", bus.valid_out, bus.data_out);
    end
  endtask

  task automatic test_random();
    int sz;
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 99) < 55, 6'($urandom), $urandom_range(0, 99) < 48);
      sz = mq.size();
      n_cmp += 5;
      if (bus.count !== 4'(sz)) begin n_fail++; $display("FAIL rnd_count %0d: got %0d want %0d", k, bus.count, sz); end
      if (bus.full !== (sz == 8) || bus.empty !== (sz == 0)) begin
        n_fail++; $display("FAIL rnd_fe %0d: got %0b%0b want %0b%0b", k, bus.full, bus.empty, sz == 8, sz == 0);
      end
      if (bus.almost_full !== (sz >= 6) || bus.almost_empty !== (sz <= 2)) begin
        n_fail++; $display("FAIL rnd_almost %0d: got %0b%0b at count %0d", k, bus.almost_full, bus.almost_empty, sz);
      end
      if (bus.valid_out !== m_vld || bus.data_out !== m_dout) begin
        n_fail++; $display("FAIL rnd_data %0d: got %0b/%0h want %0b/%0h", k, bus.valid_out, bus.data_out, m_vld, m_dout);
      end
      if (bus.fifo_error !== m_err) begin n_fail++; $display("FAIL rnd_err %0d: got %0b want %0b", k, bus.fifo_error, m_err); end
    end
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    model_clear();
    #1;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_wrap();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
